fp_operand_aligner: RTL and testbench
=====================================

// Module: fp_operand_aligner
// PURPOSE
//  Front end of the FP adder; runs ahead of the post-add normalizer. Accepts two IEEE-754 operands and
//  unpacks them. Orders them by magnitude. Right-shifts the smaller mantissa one bit per cycle until it
//  matches the larger exponent. Presents the common exponent and both aligned mantissas (with guard and
//  round bits) to the adder core over a valid/ready handshake.
// PARAMETERS
//  EXP_WIDTH       8   exponent field width
//  MANTISSA_WIDTH  23  stored fraction width (hidden bit excluded)
// PORTS
//  clock_in        in   1               single clock, rising edge
//  reset_in        in   1               asynchronous, active-high reset
//  valid_in        in   1               operands present
//  ready_out       out  1               aligner can accept (state IDLE)
//  a_in, b_in      in   1+E+M each      packed {sign, exponent, fraction}
//  valid_out       out  1               aligned result held on outputs
//  ready_in        in   1               downstream consumes result
//  exp_out         out  E               common (larger) exponent
//  big_m_out       out  M+3             {hidden, fraction, guard, round} of larger operand
//  small_m_out     out  M+3             same layout, smaller operand after shift
//  big_sign_out    out  1               sign of larger operand
//  small_sign_out  out  1               sign of smaller operand
//  swap_out        out  1               1 = B was larger (B routed to big_*)
//  sticky_out      out  1               OR of all bits shifted out of small_m
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, ready_out=1, every other output=0.
//  - Unpack: hidden bit=(exp!=0); exponent 0 is treated as effective exponent 1 for shift math.
//    exp_out reports the raw field.
//  - Order: big = larger {exp, fraction}; on an exact tie A is big and swap_out=0.
//  - Shift amount d = eff_exp(big) - eff_exp(small), unsigned E bits.
//    Clamp dc = min(d, SHIFT_MAX), SHIFT_MAX = M+3. Counter width $clog2(SHIFT_MAX+1).
//  - FSM IDLE -> ALIGN -> DONE -> IDLE:
//    IDLE:  on valid_in & ready_out, register unpacked and ordered operands; count=dc; go to ALIGN.
//    ALIGN: if count!=0, small_m >>= 1, sticky |= shifted-out LSB, count--.
//           If count==0, go to DONE and assert valid_out.
//    DONE:  hold all outputs stable. On ready_in, drop valid_out and go to IDLE.
//  - Latency from the accept edge to valid_out = dc+1 cycles. Minimum IDLE->IDLE occupancy = dc+2 cycles.
//  - ready_out=0 in ALIGN and DONE. valid_in is ignored there; the upstream holds its data.
//  - valid_out and ready_in both high in DONE: result consumed. ready_out rises the next cycle.
//    No same-cycle accept.
//  - dc==SHIFT_MAX: small_m_out=0 and sticky_out=|(original small_m).
//  - Inf/NaN are not special-cased; they align like ordinary numbers.
// CONFIGURATION
//  FP_ALIGN_STICKY_EN defined: sticky accumulates as above.
//  Undefined: the sticky register is omitted, sticky_out is tied 0, and shifted-out bits are discarded.
//  Latency is identical in both builds.
// STRUCTURE
//  - Shared package fp_pkg: EXP_WIDTH/MANTISSA_WIDTH defaults, packed struct fp_t {sign, exp, frac},
//    SHIFT_MAX constant, align_state_t enum {IDLE, ALIGN, DONE}.
//  - Sub-module fp_operand_order (combinational): unpack, magnitude compare, swap, compute dc.
//    The top keeps the FSM, counter and shift registers.
// TESTING
//  1. A=3F800000, B=3F000000 -> d=1: exp_out=7F, big_m=2000000, small_m=1000000, swap=0, sticky=0.
//     valid_out 2 cycles after accept.
//  2. A=3FC00000, B=3FE00000 -> d=0: swap_out=1, big_m=3800000, small_m=3000000. Latency 1.
//  3. A=4B800000, B=3F800001 -> d=24: small_m=0000002, sticky_out=1 (0 if macro off), exp_out=97.
//     Latency 25.
//  4. A=7F000000, B=3F800000 -> d=127 clamped to 26: small_m=0, sticky_out=1. Latency 27.
//  5. ready_in low 5 cycles in DONE: outputs bit-stable, ready_out=0, a pulsed valid_in is not accepted.
//     Then consume once.
//  6. reset_in pulsed mid-ALIGN (case 4, cycle 10): outputs go to 0 and ready_out to 1 without a clock edge.
//     The next op (case 1) then completes correctly.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the FP adder front end: default field widths, operand layout, aligner states.
package fp_pkg;

    localparam int unsigned FP_EXP_WIDTH  = 8;
    localparam int unsigned FP_MANT_WIDTH = 23;
    localparam int unsigned FP_SHIFT_MAX  = FP_MANT_WIDTH + 3;

    typedef struct packed {
        logic                     sign;
        logic [FP_EXP_WIDTH-1:0]  exp;
        logic [FP_MANT_WIDTH-1:0] frac;
    } fp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        DONE  = 2'd2
    } align_state_t;

endpackage

// File: rtl/fp_operand_order.sv
// Combinational unpack, magnitude ordering and clamped exponent-difference for the operand aligner.
module fp_operand_order #(
    parameter int unsigned EXP_WIDTH      = 8,
    parameter int unsigned MANTISSA_WIDTH = 23,
    localparam int unsigned W  = 1 + EXP_WIDTH + MANTISSA_WIDTH,
    localparam int unsigned MW = MANTISSA_WIDTH + 3,
    localparam int unsigned CW = $clog2(MW + 1)
) (
    input  logic [W-1:0]         a_in,
    input  logic [W-1:0]         b_in,
    output logic                 big_sign_o,
    output logic                 small_sign_o,
    output logic [EXP_WIDTH-1:0] big_exp_o,
    output logic [MW-1:0]        big_m_o,
    output logic [MW-1:0]        small_m_o,
    output logic                 swap_o,
    output logic [CW-1:0]        dc_o
);

    logic                      a_sign, b_sign;
    logic [EXP_WIDTH-1:0]      a_exp, b_exp, a_eff, b_eff, big_eff, small_eff, diff;
    logic [MANTISSA_WIDTH-1:0] a_frac, b_frac;
    logic [MW-1:0]             a_m, b_m;
    logic [31:0]               diff_ext;

    assign {a_sign, a_exp, a_frac} = a_in;
    assign {b_sign, b_exp, b_frac} = b_in;

    // Denormals (exp field 0) shift as if their exponent were 1.
    assign a_eff = (a_exp == '0) ? EXP_WIDTH'(1) : a_exp;
    assign b_eff = (b_exp == '0) ? EXP_WIDTH'(1) : b_exp;
    assign a_m   = {(a_exp != '0), a_frac, 2'b00};
    assign b_m   = {(b_exp != '0), b_frac, 2'b00};

    assign swap_o = ({b_exp, b_frac} > {a_exp, a_frac});

    always_comb begin
        big_sign_o   = a_sign;
        small_sign_o = b_sign;
        big_exp_o    = a_exp;
        big_m_o      = a_m;
        small_m_o    = b_m;
        big_eff      = a_eff;
        small_eff    = b_eff;
        if (swap_o) begin
            big_sign_o   = b_sign;
            small_sign_o = a_sign;
            big_exp_o    = b_exp;
            big_m_o      = b_m;
            small_m_o    = a_m;
            big_eff      = b_eff;
            small_eff    = a_eff;
        end
    end

    assign diff     = big_eff - small_eff;
    assign diff_ext = 32'(diff);
    assign dc_o     = (diff_ext > MW) ? CW'(MW) : CW'(diff_ext);

endmodule

// File: rtl/fp_operand_aligner.sv
// FP adder front end: orders operands and right-shifts the smaller mantissa one bit per cycle.
// Sticky accumulation is present only when FP_ALIGN_STICKY_EN is defined.
module fp_operand_aligner
    import fp_pkg::*;
#(
    parameter int unsigned EXP_WIDTH      = FP_EXP_WIDTH,
    parameter int unsigned MANTISSA_WIDTH = FP_MANT_WIDTH,
    localparam int unsigned W  = 1 + EXP_WIDTH + MANTISSA_WIDTH,
    localparam int unsigned MW = MANTISSA_WIDTH + 3,
    localparam int unsigned CW = $clog2(MW + 1)
) (
    input  logic                 clock_in,
    input  logic                 reset_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic [W-1:0]         a_in,
    input  logic [W-1:0]         b_in,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic [EXP_WIDTH-1:0] exp_out,
    output logic [MW-1:0]        big_m_out,
    output logic [MW-1:0]        small_m_out,
    output logic                 big_sign_out,
    output logic                 small_sign_out,
    output logic                 swap_out,
    output logic                 sticky_out
);

    logic                 ord_big_sign, ord_small_sign, ord_swap;
    logic [EXP_WIDTH-1:0] ord_exp;
    logic [MW-1:0]        ord_big_m, ord_small_m;
    logic [CW-1:0]        ord_dc;

    fp_operand_order #(
        .EXP_WIDTH      (EXP_WIDTH),
        .MANTISSA_WIDTH (MANTISSA_WIDTH)
    ) u_order (
        .a_in         (a_in),
        .b_in         (b_in),
        .big_sign_o   (ord_big_sign),
        .small_sign_o (ord_small_sign),
        .big_exp_o    (ord_exp),
        .big_m_o      (ord_big_m),
        .small_m_o    (ord_small_m),
        .swap_o       (ord_swap),
        .dc_o         (ord_dc)
    );

    align_state_t         state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [EXP_WIDTH-1:0] exp_q, exp_d;
    logic [MW-1:0]        big_m_q, big_m_d, small_m_q, small_m_d;
    logic                 big_sign_q, big_sign_d, small_sign_q, small_sign_d;
    logic                 swap_q, swap_d;
`ifdef FP_ALIGN_STICKY_EN
    logic                 sticky_q, sticky_d;
`endif

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q      <= IDLE;
            count_q      <= '0;
            exp_q        <= '0;
            big_m_q      <= '0;
            small_m_q    <= '0;
            big_sign_q   <= 1'b0;
            small_sign_q <= 1'b0;
            swap_q       <= 1'b0;
`ifdef FP_ALIGN_STICKY_EN
            sticky_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            exp_q        <= exp_d;
            big_m_q      <= big_m_d;
            small_m_q    <= small_m_d;
            big_sign_q   <= big_sign_d;
            small_sign_q <= small_sign_d;
            swap_q       <= swap_d;
`ifdef FP_ALIGN_STICKY_EN
            sticky_q     <= sticky_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        exp_d        = exp_q;
        big_m_d      = big_m_q;
        small_m_d    = small_m_q;
        big_sign_d   = big_sign_q;
        small_sign_d = small_sign_q;
        swap_d       = swap_q;
`ifdef FP_ALIGN_STICKY_EN
        sticky_d     = sticky_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    state_d      = ALIGN;
                    count_d      = ord_dc;
                    exp_d        = ord_exp;
                    big_m_d      = ord_big_m;
                    small_m_d    = ord_small_m;
                    big_sign_d   = ord_big_sign;
                    small_sign_d = ord_small_sign;
                    swap_d       = ord_swap;
`ifdef FP_ALIGN_STICKY_EN
                    sticky_d     = 1'b0;
`endif
                end
            end
            ALIGN: begin
                if (count_q != '0) begin
                    small_m_d = small_m_q >> 1;
                    count_d   = count_q - CW'(1);
`ifdef FP_ALIGN_STICKY_EN
                    sticky_d  = sticky_q | small_m_q[0];
`endif
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ready_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready_out      = (state_q == IDLE);
    assign valid_out      = (state_q == DONE);
    assign exp_out        = exp_q;
    assign big_m_out      = big_m_q;
    assign small_m_out    = small_m_q;
    assign big_sign_out   = big_sign_q;
    assign small_sign_out = small_sign_q;
    assign swap_out       = swap_q;
`ifdef FP_ALIGN_STICKY_EN
    assign sticky_out     = sticky_q;
`else
    assign sticky_out     = 1'b0;
`endif

endmodule

// File: tb/tb_fp_operand_aligner.sv
// Directed self-checking bench for fp_operand_aligner; sticky expectations follow FP_ALIGN_STICKY_EN.
module tb_fp_operand_aligner;

    logic        clock_in = 1'b0;
    logic        reset_in, valid_in, ready_in;
    logic        ready_out, valid_out;
    logic [31:0] a_in, b_in;
    logic [7:0]  exp_out;
    logic [25:0] big_m_out, small_m_out;
    logic        big_sign_out, small_sign_out, swap_out, sticky_out;

    int vectors = 0;
    int miscompares = 0;

`ifdef FP_ALIGN_STICKY_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    fp_operand_aligner #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23)) dut (
        .clock_in       (clock_in),
        .reset_in       (reset_in),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .a_in           (a_in),
        .b_in           (b_in),
        .valid_out      (valid_out),
        .ready_in       (ready_in),
        .exp_out        (exp_out),
        .big_m_out      (big_m_out),
        .small_m_out    (small_m_out),
        .big_sign_out   (big_sign_out),
        .small_sign_out (small_sign_out),
        .swap_out       (swap_out),
        .sticky_out     (sticky_out)
    );

    always #5 clock_in = ~clock_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Present operands for one cycle; returns after the accept edge (+1).
    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock_in);
        a_in     = a;
        b_in     = b;
        valid_in = 1'b1;
        @(posedge clock_in);
        #1;
        valid_in = 1'b0;
        check("ready_low_after_accept", {31'b0, ready_out}, 32'd0);
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (!valid_out && lat < 100) begin
            @(posedge clock_in);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
    endtask

    task automatic check_result(input string tag, input logic [7:0] e, input logic [25:0] bm,
                                input logic [25:0] sm, input logic sw, input logic st);
        check({tag, "_exp"},     {24'b0, exp_out}, {24'b0, e});
        check({tag, "_big_m"},   {6'b0, big_m_out}, {6'b0, bm});
        check({tag, "_small_m"}, {6'b0, small_m_out}, {6'b0, sm});
        check({tag, "_swap"},    {31'b0, swap_out}, {31'b0, sw});
        check({tag, "_sticky"},  {31'b0, sticky_out}, {31'b0, st});
    endtask

    task automatic consume(input string tag);
        @(negedge clock_in);
        ready_in = 1'b1;
        @(posedge clock_in);
        #1;
        ready_in = 1'b0;
        check({tag, "_valid_dropped"}, {31'b0, valid_out}, 32'd0);
        check({tag, "_ready_back"},    {31'b0, ready_out}, 32'd1);
    endtask

    logic [31:0] snap_exp, snap_big, snap_small, snap_flags;

    initial begin
        reset_in = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b0;
        a_in     = '0;
        b_in     = '0;
        #12;
        check("rst_ready",  {31'b0, ready_out}, 32'd1);
        check("rst_valid",  {31'b0, valid_out}, 32'd0);
        check("rst_outs",   {6'b0, big_m_out | small_m_out}, 32'd0);
        check("rst_flags",  {24'b0, exp_out, big_sign_out, small_sign_out, swap_out, sticky_out}, 32'd0);
        @(negedge clock_in);
        reset_in = 1'b0;

        // Case 1: d=1
        accept(32'h3F800000, 32'h3F000000);
        wait_valid("c1", 2);
        check_result("c1", 8'h7F, 26'h2000000, 26'h1000000, 1'b0, 1'b0);
        consume("c1");

        // Case 2: d=0, B larger
        accept(32'h3FC00000, 32'h3FE00000);
        wait_valid("c2", 1);
        check_result("c2", 8'h7F, 26'h3800000, 26'h3000000, 1'b1, 1'b0);
        consume("c2");

        // Case 3: d=24
        accept(32'h4B800000, 32'h3F800001);
        wait_valid("c3", 25);
        check_result("c3", 8'h97, 26'h2000000, 26'h0000002, 1'b0, STK);
        consume("c3");

        // Case 4: d=127 clamped to 26
        accept(32'h7F000000, 32'h3F800000);
        wait_valid("c4", 27);
        check_result("c4", 8'hFE, 26'h2000000, 26'h0000000, 1'b0, STK);
        consume("c4");

        // Case 5: stall in DONE, stray valid_in ignored
        accept(32'hBF800000, 32'h3F000000);
        wait_valid("c5", 2);
        snap_exp   = {24'b0, exp_out};
        snap_big   = {6'b0, big_m_out};
        snap_small = {6'b0, small_m_out};
        snap_flags = {28'b0, big_sign_out, small_sign_out, swap_out, sticky_out};
        check("c5_big_sign", {31'b0, big_sign_out}, 32'd1);
        check("c5_small_sign", {31'b0, small_sign_out}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock_in);
            if (i == 2) begin
                a_in     = 32'h40000000;
                b_in     = 32'h40400000;
                valid_in = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
            @(posedge clock_in);
            #1;
            check("c5_hold_valid", {31'b0, valid_out}, 32'd1);
            check("c5_hold_ready", {31'b0, ready_out}, 32'd0);
            check("c5_hold_exp",   {24'b0, exp_out}, snap_exp);
            check("c5_hold_big",   {6'b0, big_m_out}, snap_big);
            check("c5_hold_small", {6'b0, small_m_out}, snap_small);
            check("c5_hold_flags", {28'b0, big_sign_out, small_sign_out, swap_out, sticky_out}, snap_flags);
        end
        valid_in = 1'b0;
        check("c5_exp_val", snap_exp, 32'h7F);
        check("c5_big_val", snap_big, 32'h2000000);
        consume("c5");

        // Case 6: async reset mid-ALIGN
        accept(32'h7F000000, 32'h3F800000);
        repeat (9) @(posedge clock_in);
        #1;
        check("c6_mid_align_valid", {31'b0, valid_out}, 32'd0);
        reset_in = 1'b1;
        #1;
        check("c6_rst_ready", {31'b0, ready_out}, 32'd1);
        check("c6_rst_outs",  {6'b0, big_m_out | small_m_out}, 32'd0);
        check("c6_rst_flags", {24'b0, exp_out, big_sign_out, small_sign_out, swap_out, sticky_out}, 32'd0);
        @(negedge clock_in);
        reset_in = 1'b0;
        accept(32'h3F800000, 32'h3F000000);
        wait_valid("c6b", 2);
        check_result("c6b", 8'h7F, 26'h2000000, 26'h1000000, 1'b0, 1'b0);
        consume("c6b");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
